gates: RTL and testbench
========================

Name: gates

Overview:
- Registered bank of seven basic two-input logic functions (AND, OR, NAND, NOR, XOR, XNOR, NOT) over operands a and b.
- Each function drives its own slice of the output bus y.
- Used as a primitive logic-function unit and a bring-up/lab block. With default WIDTH=1, y is a 7-bit vector with one bit per gate.
- Optional per-gate enable mask and a valid qualifier allow gating individual functions and tracking result freshness.

Parameters:
- WIDTH, 1, bit width of each operand; every gate operates bitwise across WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands valid; capture on this cycle.
- gate_en  input  7  per-gate enable mask; bit k enables function k.
- y  output  7*WIDTH  registered gate results; slice k = y[k*WIDTH +: WIDTH].
- out_valid  output  1  y updated from a capture on the previous cycle.

Behaviour:
- Slice mapping (k = slice index):
  - k0 = a AND b
  - k1 = a OR b
  - k2 = NAND (~(a&b))
  - k3 = NOR (~(a|b))
  - k4 = XOR (a^b)
  - k5 = XNOR (~(a^b))
  - k6 = NOT a (~a; b ignored)
- All functions are bitwise over WIDTH bits. There is no carry or cross-bit interaction.
- Reset: when rst_n is low, y=0 and out_valid=0 immediately (asynchronous), independent of clk. Both hold while rst_n is low.
- Reset release: first capture occurs at the first rising clk edge with rst_n high and in_valid=1.
- Capture: on a rising edge with in_valid=1, slice k <= gate_en[k] ? f_k(a,b) : 0.
  - out_valid <= 1.
  - Latency is exactly 1 cycle from operand presentation to y.
- Hold: on a rising edge with in_valid=0, y holds its previous value and out_valid <= 0.
- Back-to-back in_valid: every cycle is captured, giving full throughput of 1 result per cycle with no bubbles.
- gate_en is sampled together with a/b at the capture edge. A disabled slice reads 0 even for inverting gates (NAND/NOR/XNOR/NOT).
- gate_en changes while in_valid=0 have no effect on y.
- Reset asserted mid-stream clears y and out_valid at once. Operands presented in the reset cycle are discarded.
- No combinational path from any input to y or out_valid.
- X/Z on a or b propagates per standard Verilog operator rules. There is no sanitisation.

Test Plan:
- Reset: rst_n=0 with a=1, b=1, in_valid=1 toggling -> y=7'h00, out_valid=0 throughout. Release, then capture -> y valid one edge later.
- Truth table (WIDTH=1, gate_en=7'h7F, in_valid=1). Sweep (a,b)=(0,0),(0,1),(1,0),(1,1) on consecutive cycles -> y=7'h6C, 7'h56, 7'h16, 7'h23 respectively, each one cycle after application, out_valid=1 on each.
- Hold: apply a=1, b=1 capture (y=7'h23), then in_valid=0 with a=0, b=0 for 5 cycles -> y stays 7'h23, out_valid=0.
- Mask: gate_en=7'b0101010, a=0, b=0, in_valid=1 -> y=7'h28. Only NOR and XNOR survive; NAND and NOT are masked to 0.
- Async reset mid-stream: capture a=0, b=1 (y=7'h56), then assert rst_n low between clock edges -> y=0 and out_valid=0 before the next edge.
- Vector (WIDTH=4): a=4'b1100, b=4'b1010, all enabled -> slices AND=1000, OR=1110, NAND=0111, NOR=0001, XOR=0110, XNOR=1001, NOT=0011.

Source files
------------

// File: rtl/gates.sv
// gates: registered bank of seven bitwise two-input logic functions.
// Slice k of y holds function k of (a, b), or zero when gate_en[k] is low.
// Results are captured on in_valid and held otherwise.
// out_valid marks the cycle right after a capture.
module gates #(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 in_valid,
   input  logic [6:0]           gate_en,
   output logic [7*WIDTH-1:0]   y,
   output logic                 out_valid
);

   // Slice index of each logic function on the output bus
   typedef enum logic [2:0] {
      GATE_AND  = 3'd0,
      GATE_OR   = 3'd1,
      GATE_NAND = 3'd2,
      GATE_NOR  = 3'd3,
      GATE_XOR  = 3'd4,
      GATE_XNOR = 3'd5,
      GATE_NOT  = 3'd6
   } gate_id_e;

   localparam int NUM_GATES = 7;

   logic [7*WIDTH-1:0] y_d;
   logic [7*WIDTH-1:0] y_q;
   logic               out_valid_d;
   logic               out_valid_q;

   // Evaluate one logic function bitwise over the operands.
   // Operator semantics are kept as-is, so X/Z on a or b propagates naturally.
   function automatic logic [WIDTH-1:0] gate_fn(input gate_id_e  id,
                                                input logic [WIDTH-1:0] op_a,
                                                input logic [WIDTH-1:0] op_b);
      logic [WIDTH-1:0] res;
      case (id)
         GATE_AND:  res = op_a & op_b;
         GATE_OR:   res = op_a | op_b;
         GATE_NAND: res = ~(op_a & op_b);
         GATE_NOR:  res = ~(op_a | op_b);
         GATE_XOR:  res = op_a ^ op_b;
         GATE_XNOR: res = ~(op_a ^ op_b);
         GATE_NOT:  res = ~op_a;
         default:   res = {WIDTH{1'b0}};
      endcase
      return res;
   endfunction

   // Next-state: capture masked gate results on in_valid, otherwise hold y
   always_comb begin
      y_d         = y_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         out_valid_d = 1'b1;
         for (int k = 0; k < NUM_GATES; k++) begin
            if (gate_en[k]) begin
               y_d[k*WIDTH +: WIDTH] = gate_fn(gate_id_e'(3'(k)), a, b);
            end else begin
               // A disabled slice reads zero, even for inverting gates
               y_d[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end
         end
      end else begin
         y_d         = y_q;
         out_valid_d = 1'b0;
      end
   end

   // Result and valid registers; reset clears both immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q         <= {(7*WIDTH){1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign y         = y_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gates.sv
// tb_gates: directed and random checks of gates at WIDTH=1 and WIDTH=4.
// Expected results are queued when operands are driven.
// They are popped and compared one clock edge later.
module tb_gates;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [0:0]  a1, b1;
   logic [3:0]  a4, b4;
   logic        vld;
   logic [6:0]  en;
   logic [6:0]  y1;
   logic [27:0] y4;
   logic        ov1, ov4;

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0]  q1 [$];
   logic [27:0] q4 [$];
   logic [6:0]  h1;
   logic [27:0] h4;

   always #5 clk = ~clk;

   gates #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(vld),
      .gate_en(en), .y(y1), .out_valid(ov1)
   );

   gates #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(vld),
      .gate_en(en), .y(y4), .out_valid(ov4)
   );

   // Reference model: a truth-table lookup per gate, indexed by {a_i, b_i}
   function automatic logic [27:0] model(input int w, input logic [3:0] ma,
                                         input logic [3:0] mb, input logic [6:0] men);
      logic [27:0] tt;
      logic [27:0] r;
      tt = 28'h39617E8;  // nibble k = outputs of gate k for {a,b} = 3..0
      r  = 28'h0;
      for (int k = 0; k < 7; k++) begin
         for (int i = 0; i < w; i++) begin
            if (men[k]) r[k*w + i] = tt[k*4 + int'({ma[i], mb[i]})];
         end
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One cycle: drive at the falling edge, compare just after the rising edge
   task automatic step(input logic [3:0] sa, input logic [3:0] sb, input logic sv,
                       input logic [6:0] sen, input logic [6:0] exp1, input string tag);
      @(negedge clk);
      a1  = sa[0];
      b1  = sb[0];
      a4  = sa;
      b4  = sb;
      vld = sv;
      en  = sen;
      if (sv) begin
         q1.push_back(exp1);
         q4.push_back(model(4, sa, sb, sen));
      end
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
         h1 = q1.pop_front();
         h4 = q4.pop_front();
         check({tag, " valid1"}, 28'(ov1), 28'h1);
         check({tag, " valid4"}, 28'(ov4), 28'h1);
      end else begin
         check({tag, " valid1"}, 28'(ov1), 28'h0);
         check({tag, " valid4"}, 28'(ov4), 28'h0);
      end
      check({tag, " y1"}, 28'(y1), 28'(h1));
      check({tag, " y4"}, y4, h4);
   endtask

   initial begin
      logic [27:0] m;
      logic [3:0]  ra, rb;
      logic [6:0]  ren;

      rst_n = 1'b0;
      a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
      vld = 1'b1; en = 7'h7F;
      h1 = 7'h00; h4 = 28'h0;

      // Reset held with live, toggling operands: outputs stay cleared
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("rst y1", 28'(y1), 28'h0);
         check("rst ov1", 28'(ov1), 28'h0);
         check("rst y4", y4, 28'h0);
         vld = ~vld;
      end
      @(negedge clk);
      rst_n = 1'b1;
      vld   = 1'b0;

      // First capture after release, then the truth-table sweep back to back
      step(4'hF, 4'hF, 1'b1, 7'h7F, 7'h23, "first");
      step(4'h0, 4'h0, 1'b1, 7'h7F, 7'h6C, "tt00");
      step(4'h0, 4'hF, 1'b1, 7'h7F, 7'h56, "tt01");
      step(4'hF, 4'h0, 1'b1, 7'h7F, 7'h16, "tt10");
      step(4'hF, 4'hF, 1'b1, 7'h7F, 7'h23, "tt11");

      // Hold: idle cycles with changed operands keep y
      for (int i = 0; i < 5; i++) begin
         step(4'h0, 4'h0, 1'b0, 7'h7F, 7'h00, "hold");
      end
      check("hold const", 28'(y1), 28'h23);

      // Mask: only NOR and XNOR survive
      step(4'h0, 4'h0, 1'b1, 7'b0101010, 7'h28, "mask");
      // gate_en change while idle has no effect
      step(4'hF, 4'h0, 1'b0, 7'h00, 7'h00, "idle_en");
      check("idle_en const", 28'(y1), 28'h28);

      // Vector operands on the WIDTH=4 instance
      step(4'hC, 4'hA, 1'b1, 7'h7F, 7'h6C, "vec");
      check("vec const", y4, 28'h39617E8);

      // Asynchronous reset between edges discards the pending capture
      step(4'h0, 4'hF, 1'b1, 7'h7F, 7'h56, "pre_rst");
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF; vld = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async y1", 28'(y1), 28'h0);
      check("async ov1", 28'(ov1), 28'h0);
      check("async y4", y4, 28'h0);
      @(posedge clk);
      #1;
      check("rst edge y1", 28'(y1), 28'h0);
      check("rst edge ov1", 28'(ov1), 28'h0);
      h1 = 7'h00;
      h4 = 28'h0;
      @(negedge clk);
      rst_n = 1'b1;
      vld   = 1'b0;
      step(4'h0, 4'h0, 1'b0, 7'h7F, 7'h00, "post_rst");
      step(4'h0, 4'hF, 1'b1, 7'h7F, 7'h56, "recap");

      // Random operands and masks against the truth-table model
      for (int i = 0; i < 24; i++) begin
         ra  = 4'($urandom_range(15, 0));
         rb  = 4'($urandom_range(15, 0));
         ren = 7'($urandom_range(127, 0));
         m   = model(1, ra, rb, ren);
         step(ra, rb, 1'($urandom_range(1, 0)), ren, m[6:0], "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
